data_mem_ctrl: RTL and testbench

- Data-memory stage directly downstream of the MDR/AR registers in the image-processing datapath.
- Accepts single-word read and write requests from the control unit. Writes the 16-bit word supplied on the MDR's RAM output. Returns read words on a bus that feeds the MDR's RAM input.
- Holds an internal synchronous single-port RAM with a programmable read latency. A pulsed rd_valid tells the control unit exactly when to assert the MDR RAM-load control bit.

---
 rtl/data_mem_ctrl.sv | 113 +++++++++++
 tb/tb_data_mem_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory stage behind MDR/AR: single-port synchronous RAM with a programmable
// read latency, pulsed rd_valid / wr_done handshakes and a write-wins collision rule.
//
// state   | meaning
// IDLE    | accepts read/write requests
// RD_WAIT | read in flight, latency counter runs, busy high
// RD_OUT  | rd_data presented with rd_valid; may accept the next request
module data_mem_ctrl #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              wr_done,
  output logic              busy,
  output logic              collision
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_OUT} state_t;

  localparam logic [2:0] LAST_CNT = 3'(READ_LAT - 1);

  generate
    if (READ_LAT < 1 || READ_LAT > 8) begin : g_bad_read_lat
      $error("data_mem_ctrl: READ_LAT must be in 1..8");
    end
  endgenerate

  state_t            state;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  logic              can_accept;
  logic              acc_wr;
  logic              acc_rd;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_raddr;

  assign can_accept = (state == IDLE) || (state == RD_OUT);
  assign acc_wr     = can_accept && wr_req;
  assign acc_rd     = can_accept && rd_req && !wr_req;

  // The RAM port is read once per transaction: at acceptance for READ_LAT=1,
  // otherwise on the final wait cycle using the address latched at acceptance.
  assign mem_re    = (READ_LAT == 1) ? acc_rd : ((state == RD_WAIT) && (cnt == LAST_CNT));
  assign mem_raddr = (READ_LAT == 1) ? addr : rd_addr_q;

  always_ff @(posedge Clk) begin
    if (!Rst && acc_wr) begin
      mem[addr] <= wr_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_addr_q <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      wr_done   <= 1'b0;
      busy      <= 1'b0;
      collision <= 1'b0;
    end else begin
      rd_valid  <= 1'b0;
      wr_done   <= 1'b0;
      collision <= 1'b0;
      if (mem_re) begin
        rd_data  <= mem[mem_raddr];
        rd_valid <= 1'b1;
      end
      case (state)
        IDLE, RD_OUT: begin
          if (acc_wr) begin
            state     <= IDLE;
            wr_done   <= 1'b1;
            collision <= rd_req;
          end else if (acc_rd) begin
            rd_addr_q <= addr;
            if (READ_LAT == 1) begin
              state <= RD_OUT;
            end else begin
              state <= RD_WAIT;
              cnt   <= 3'd1;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        RD_WAIT: begin
          if (cnt == LAST_CNT) begin
            state <= RD_OUT;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances (READ_LAT 2, 4, 1) share one stimulus stream
// and are each checked every cycle against a transaction-level model.
module tb_data_mem_ctrl;

  logic        Clk;
  logic        Rst;
  logic [11:0] addr;
  logic [15:0] wr_data;
  logic        rd_req;
  logic        wr_req;

  logic [15:0] rdd [3];
  logic        rdv [3];
  logic        wrd [3];
  logic        bsy [3];
  logic        col [3];

  int     lat [3] = '{2, 4, 1};
  int     n_vec = 0;
  int     n_err = 0;
  longint ncyc  = 0;
  bit     chk_en = 0;

  // model state: a read accepted at edge t completes at edge t+L-1, next accept at t+L
  logic [15:0] mm    [3][4096];
  bit          known [3][4096];
  longint      free_e [3];
  longint      vedge  [3];
  bit          vpend  [3];
  logic [11:0] paddr  [3];
  logic [15:0] e_rdd [3];
  bit          e_rdk [3];
  bit          e_rdv [3];
  bit          e_wrd [3];
  bit          e_bsy [3];
  bit          e_col [3];
  int          vcnt  [3];
  logic [15:0] got0 [$];

  data_mem_ctrl #(.ADDR_W(12), .DATA_W(16), .READ_LAT(2)) u_l2 (
    .Clk(Clk), .Rst(Rst), .addr(addr), .wr_data(wr_data), .rd_req(rd_req), .wr_req(wr_req),
    .rd_data(rdd[0]), .rd_valid(rdv[0]), .wr_done(wrd[0]), .busy(bsy[0]), .collision(col[0]));
  data_mem_ctrl #(.ADDR_W(12), .DATA_W(16), .READ_LAT(4)) u_l4 (
    .Clk(Clk), .Rst(Rst), .addr(addr), .wr_data(wr_data), .rd_req(rd_req), .wr_req(wr_req),
    .rd_data(rdd[1]), .rd_valid(rdv[1]), .wr_done(wrd[1]), .busy(bsy[1]), .collision(col[1]));
  data_mem_ctrl #(.ADDR_W(12), .DATA_W(16), .READ_LAT(1)) u_l1 (
    .Clk(Clk), .Rst(Rst), .addr(addr), .wr_data(wr_data), .rd_req(rd_req), .wr_req(wr_req),
    .rd_data(rdd[2]), .rd_valid(rdv[2]), .wr_done(wrd[2]), .busy(bsy[2]), .collision(col[2]));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  task automatic model_edge(input int i);
    if (Rst) begin
      free_e[i] = ncyc + 1;
      vpend[i]  = 0;
      e_rdv[i]  = 0;
      e_wrd[i]  = 0;
      e_bsy[i]  = 0;
      e_col[i]  = 0;
      e_rdd[i]  = 16'h0000;
      e_rdk[i]  = 1;
      chk_en    = 1;
      return;
    end
    e_rdv[i] = 0;
    e_wrd[i] = 0;
    e_col[i] = 0;
    if (ncyc >= free_e[i]) begin
      if (wr_req) begin
        mm[i][addr]    = wr_data;
        known[i][addr] = 1;
        e_wrd[i]       = 1;
        e_col[i]       = rd_req;
        free_e[i]      = ncyc + 1;
      end else if (rd_req) begin
        paddr[i]  = addr;
        vpend[i]  = 1;
        vedge[i]  = ncyc + lat[i] - 1;
        free_e[i] = ncyc + lat[i];
      end
    end
    if (vpend[i] && vedge[i] == ncyc) begin
      e_rdv[i] = 1;
      e_rdd[i] = mm[i][paddr[i]];
      e_rdk[i] = known[i][paddr[i]];
      vpend[i] = 0;
    end
    e_bsy[i] = vpend[i];
  endtask

  task automatic compare(input int i);
    chk($sformatf("rd_valid[L%0d]", lat[i]), {15'd0, rdv[i]}, {15'd0, e_rdv[i]});
    chk($sformatf("wr_done[L%0d]", lat[i]), {15'd0, wrd[i]}, {15'd0, e_wrd[i]});
    chk($sformatf("busy[L%0d]", lat[i]), {15'd0, bsy[i]}, {15'd0, e_bsy[i]});
    chk($sformatf("collision[L%0d]", lat[i]), {15'd0, col[i]}, {15'd0, e_col[i]});
    if (e_rdk[i]) chk($sformatf("rd_data[L%0d]", lat[i]), rdd[i], e_rdd[i]);
    if (rdv[i] === 1'b1) begin
      vcnt[i]++;
      if (i == 0) got0.push_back(rdd[0]);
    end
  endtask

  always @(posedge Clk) begin
    for (int i = 0; i < 3; i++) model_edge(i);
    ncyc++;
    #1;
    if (chk_en) for (int i = 0; i < 3; i++) compare(i);
  end

  task automatic step(input logic r, input logic w, input logic [11:0] a,
                      input logic [15:0] d, input logic rs);
    @(negedge Clk);
    rd_req  = r;
    wr_req  = w;
    addr    = a;
    wr_data = d;
    Rst     = rs;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
  endtask

  task automatic after_edge();
    @(posedge Clk);
    #2;
  endtask

  initial begin
    int v1;
    Rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; addr = '0; wr_data = '0;
    step(1'b0, 1'b0, 12'h000, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 12'h000, 16'h0000, 1'b1);
    idle(10);
    after_edge();
    chk("reset rd_data", rdd[0], 16'h0000);
    chk("reset busy", {15'd0, bsy[1]}, 16'h0000);
    chk("model reset rd_data", e_rdd[0], 16'h0000);

    // write then read, READ_LAT=2 timing pinned by literals
    step(1'b0, 1'b1, 12'h010, 16'hBEEF, 1'b0);
    after_edge();
    chk("wr_done pulse", {15'd0, wrd[0]}, 16'h0001);
    step(1'b1, 1'b0, 12'h010, 16'h0000, 1'b0);
    after_edge();
    chk("busy L2 after accept", {15'd0, bsy[0]}, 16'h0001);
    chk("rd_valid L2 not yet", {15'd0, rdv[0]}, 16'h0000);
    step(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
    after_edge();
    chk("rd_valid L2 2nd cycle", {15'd0, rdv[0]}, 16'h0001);
    chk("rd_data L2 BEEF", rdd[0], 16'hBEEF);
    chk("model rd_data BEEF", e_rdd[0], 16'hBEEF);
    idle(6);

    // back-to-back reads with an address switch at the RD_OUT edge
    step(1'b0, 1'b1, 12'h001, 16'h1111, 1'b0);
    step(1'b0, 1'b1, 12'h002, 16'h2222, 1'b0);
    idle(5);
    got0.delete();
    step(1'b1, 1'b0, 12'h001, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 12'h001, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 12'h002, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 12'h002, 16'h0000, 1'b0);
    idle(6);
    chk("b2b count", 16'(got0.size()), 16'd2);
    chk("b2b first", (got0.size() > 0) ? got0[0] : 16'hDEAD, 16'h1111);
    chk("b2b second", (got0.size() > 1) ? got0[1] : 16'hDEAD, 16'h2222);

    // collision: write wins
    step(1'b1, 1'b1, 12'h0FF, 16'h00A5, 1'b0);
    after_edge();
    chk("collision pulse", {15'd0, col[0]}, 16'h0001);
    chk("collision wr_done", {15'd0, wrd[1]}, 16'h0001);
    chk("collision no rd_valid", {15'd0, rdv[2]}, 16'h0000);
    idle(6);
    step(1'b1, 1'b0, 12'h0FF, 16'h0000, 1'b0);
    idle(6);
    for (int i = 0; i < 3; i++) chk($sformatf("read after collision L%0d", lat[i]), rdd[i], 16'h00A5);

    // reset in the middle of a READ_LAT=4 read
    v1 = vcnt[1];
    step(1'b1, 1'b0, 12'h010, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 12'h000, 16'h0000, 1'b1);
    idle(6);
    chk("aborted read no rd_valid", 16'(vcnt[1] - v1), 16'd0);
    chk("aborted read rd_data", rdd[1], 16'h0000);
    step(1'b1, 1'b0, 12'h010, 16'h0000, 1'b0);
    idle(6);
    chk("ram kept over reset", rdd[1], 16'hBEEF);

    // READ_LAT=1 at the top address
    step(1'b0, 1'b1, 12'hFFF, 16'h7E57, 1'b0);
    step(1'b1, 1'b0, 12'hFFF, 16'h0000, 1'b0);
    after_edge();
    chk("L1 rd_valid next cycle", {15'd0, rdv[2]}, 16'h0001);
    chk("L1 rd_data", rdd[2], 16'h7E57);
    chk("L1 busy", {15'd0, bsy[2]}, 16'h0000);
    idle(6);

    for (int k = 0; k < 3000; k++) begin
      logic [11:0] a;
      a = ($urandom % 8 == 0) ? 12'hFFF : 12'($urandom % 8);
      step(($urandom % 3) == 0, ($urandom % 4) == 0, a, 16'($urandom),
           ($urandom % 150) == 0);
    end
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
